// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg: shared arbiter state type for the fractal sync tx path
package fractal_sync_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_e;
endpackage

// File: rtl/fractal_sync_rr_sel.sv
// fractal_sync_rr_sel: round-robin pick of the first set i_req bit at or above i_ptr (wrapping); outputs one-hot o_gnt, o_idx, o_any
module fractal_sync_rr_sel #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      automatic int j = (int'(i_ptr) + i) % N;
      if (!o_any && i_req[j]) begin
        o_any = 1'b1;
        o_idx = IW'(j);
        o_gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fractal_sync_tx_arb.sv
// fractal_sync_tx_arb: round-robin arbiter forwarding N_RX fifo heads (empty_i/req_i, pop_o) into one registered req_o/valid_o/ready_i/grant_o stage with stall_o back-pressure flag
module fractal_sync_tx_arb
  import fractal_sync_pkg::*;
#(
  parameter type fsync_req_t = logic,
  parameter int  N_RX        = 2,
  parameter int  STALL_TH    = 16,
  localparam int IW          = $clog2(N_RX),
  localparam int CW          = $clog2(STALL_TH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_RX-1:0]     empty_i,
  input  fsync_req_t          req_i [N_RX],
  output logic [N_RX-1:0]     pop_o,
  output fsync_req_t          req_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [IW-1:0]       grant_o,
  output logic                stall_o
);
  arb_state_e      r_state;
  fsync_req_t      r_req;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_stall;
  logic [N_RX-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_load;
  logic            w_bp;
  logic [CW-1:0]   w_cnt;
  fractal_sync_rr_sel #(.N(N_RX)) u_sel (
    .i_req (~empty_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );
  assign w_load  = w_any & ((r_state == IDLE) | ready_i);
  assign pop_o   = (w_load & ~rst_i) ? w_gnt : '0;
  assign w_bp    = (r_state == BUSY) & ~ready_i;
  assign w_cnt   = w_bp ? ((r_cnt == CW'(STALL_TH)) ? r_cnt : r_cnt + 1'b1) : '0;
  assign valid_o = r_state == BUSY;
  assign req_o   = r_req;
  assign grant_o = r_grant;
  assign stall_o = r_stall;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_state <= w_load ? BUSY : (ready_i ? IDLE : r_state);
      if (w_load) begin
        r_req    <= req_i[w_idx];
        r_grant  <= w_idx;
        r_rr_ptr <= (w_idx == IW'(N_RX - 1)) ? '0 : w_idx + 1'b1;
      end
      r_cnt   <= w_cnt;
      r_stall <= w_cnt == CW'(STALL_TH);
    end
  end
  if (N_RX < 2 || N_RX > 8) begin : g_bad_n_rx
    $error("fractal_sync_tx_arb: N_RX must be within 2..8");
  end
  if (STALL_TH <= 0) begin : g_bad_stall_th
    $error("fractal_sync_tx_arb: STALL_TH must be positive");
  end
  a_pop_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(pop_o));
endmodule
